zone_bl_spi_tx: RTL and testbench

Consumer end of the 360-zone backlight stream (flag_done / cnt_360 / buf_360_flatted) produced by the zone statistics block.
- Captures one frame of zone values into a ping-pong buffer.
- Applies a global gain.
- Shifts the frame to the MiniLED driver over a SPI-style serial link with chip-select and latch pulse.
- Sits between zone statistics and the LED driver pins, in the pixel clock domain.

---
 rtl/zone_bl_spi_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_zone_bl_spi_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/zone_bl_spi_tx.sv
// zone_bl_spi_tx
//   Consumer end of the 360-zone backlight stream. It captures one frame of
//   zone values into a ping-pong buffer and scales each byte by a global gain
//   when it is fetched for transmit. Each frame goes to the MiniLED driver as
//   one mode-0 serial burst: a header byte, then ZONES data bytes. A latch
//   pulse follows the burst.
// Ports
//   i_pix_clk       : pixel clock, the only clock
//   rst             : synchronous reset, active high
//   flag_done       : one-cycle strobe, buf_360_flatted is valid
//   cnt_360         : producer zone counter, already advanced at the strobe
//   buf_360_flatted : zone backlight value
//   r_Vsync_0       : frame sync level; a rising edge restarts the write count
//   global_gain     : brightness gain, 255 = unity
//   o_sclk/o_sdo    : serial clock (idle low) and data (MSB first)
//   o_cs_n          : chip select, active low
//   o_latch         : driver latch pulse
//   o_busy          : transmit in progress
//   o_frame_cnt     : frames sent, wraps
//   o_overrun       : sticky, a frame completed while transmit was busy
//   o_err           : sticky, an incomplete or out-of-range frame write
module zone_bl_spi_tx #(
  parameter int         ZONES     = 360,
  parameter int         CLK_DIV   = 4,
  parameter logic [7:0] HDR       = 8'hA5,
  parameter int         LATCH_CYC = 8
) (
  input  logic       i_pix_clk,
  input  logic       rst,
  input  logic       flag_done,
  input  logic [8:0] cnt_360,
  input  logic [7:0] buf_360_flatted,
  input  logic       r_Vsync_0,
  input  logic [7:0] global_gain,
  output logic       o_sclk,
  output logic       o_sdo,
  output logic       o_cs_n,
  output logic       o_latch,
  output logic       o_busy,
  output logic [7:0] o_frame_cnt,
  output logic       o_overrun,
  output logic       o_err
);

  localparam logic [8:0]  ZONES_N    = 9'(ZONES);
  localparam logic [8:0]  ZONE_LAST  = 9'(ZONES - 1);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] LATCH_LAST = 16'(LATCH_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_HDR, S_DATA, S_STOP, S_LATCH} state_t;

  state_t      state_q;
  logic        sclk_q, sdo_q, cs_n_q, latch_q, busy_q, overrun_q, err_q;
  logic [7:0]  frame_cnt_q;
  logic        wr_bank_q, pending_q, vsync_q, phase_q;
  logic [8:0]  wr_cnt_q, rd_addr_q, byte_idx_q;
  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q, nxt_q, rd_data_q;

  // Two banks side by side: the bank bit is the top address bit
  logic [7:0]  mem_q [0:1023];

  logic [8:0] wr_addr;
  logic       wr_ok, wr_last, frame_done, wr_incomplete, vs_rise, latch_exit;
  logic [7:0] gained;

  // The producer counter has already advanced, so the zone is one behind it
  assign wr_addr       = (cnt_360 == 9'd0) ? ZONE_LAST : cnt_360 - 9'd1;
  assign wr_ok         = flag_done && (wr_addr < ZONES_N);
  assign wr_last       = wr_ok && (wr_addr == ZONE_LAST);
  assign frame_done    = wr_last && (wr_cnt_q == ZONE_LAST);
  assign wr_incomplete = wr_last && (wr_cnt_q != ZONE_LAST);
  assign vs_rise       = r_Vsync_0 && !vsync_q;
  assign latch_exit    = (state_q == S_LATCH) && (div_q == LATCH_LAST);
  // (data * (gain+1)) >> 8; gain 255 is exact identity
  assign gained        = 8'((16'(rd_data_q) * (16'(global_gain) + 16'd1)) >> 8);

  // Transmit always reads the bank that is not being written
  always_ff @(posedge i_pix_clk) begin
    if (wr_ok) mem_q[{wr_bank_q, wr_addr}] <= buf_360_flatted;
    rd_data_q <= mem_q[{~wr_bank_q, rd_addr_q}];
  end

  always_ff @(posedge i_pix_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sclk_q      <= 1'b0;
      sdo_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      latch_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      overrun_q   <= 1'b0;
      err_q       <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= 9'd0;
      pending_q   <= 1'b0;
      vsync_q     <= 1'b0;
      div_q       <= 16'd0;
      phase_q     <= 1'b0;
      bit_q       <= 3'd0;
      byte_idx_q  <= 9'd0;
      rd_addr_q   <= 9'd0;
      sh_q        <= 8'd0;
      nxt_q       <= 8'd0;
    end else begin
      vsync_q <= r_Vsync_0;

      // A strobe coinciding with the vsync edge counts as the first write
      if (vs_rise)      wr_cnt_q <= wr_ok ? 9'd1 : 9'd0;
      else if (wr_last) wr_cnt_q <= 9'd0;
      else if (wr_ok)   wr_cnt_q <= wr_cnt_q + 9'd1;

      if ((flag_done && !wr_ok) || wr_incomplete) err_q <= 1'b1;
      if (frame_done && state_q != S_IDLE) overrun_q <= 1'b1;
      // On the latch exit cycle the new frame is taken directly below
      if (frame_done && state_q != S_IDLE && !latch_exit) pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (frame_done) begin
            wr_bank_q <= ~wr_bank_q;
            state_q   <= S_START;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            div_q     <= 16'd0;
            rd_addr_q <= 9'd0;
          end
        end
        S_START: begin
          if (div_q == DIV_LAST) begin
            state_q <= S_HDR;
            div_q   <= 16'd0;
            phase_q <= 1'b0;
            bit_q   <= 3'd0;
            sh_q    <= HDR;
            sdo_q   <= HDR[7];
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_HDR, S_DATA: begin
          // Fetch the following byte mid-way through the current one so the
          // byte boundary has no gap; gain is sampled here too
          if (!phase_q && bit_q == 3'd3 && div_q == 16'd0) begin
            nxt_q     <= gained;
            rd_addr_q <= rd_addr_q + 9'd1;
          end
          if (div_q == DIV_LAST) begin
            div_q <= 16'd0;
            if (!phase_q) begin
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              sclk_q  <= 1'b0;
              phase_q <= 1'b0;
              if (bit_q != 3'd7) begin
                bit_q <= bit_q + 3'd1;
                sh_q  <= {sh_q[6:0], 1'b0};
                sdo_q <= sh_q[6];
              end else begin
                bit_q <= 3'd0;
                if (state_q == S_HDR) begin
                  state_q    <= S_DATA;
                  byte_idx_q <= 9'd0;
                  sh_q       <= nxt_q;
                  sdo_q      <= nxt_q[7];
                end else if (byte_idx_q == ZONE_LAST) begin
                  state_q <= S_STOP;
                  sdo_q   <= 1'b0;
                end else begin
                  byte_idx_q <= byte_idx_q + 9'd1;
                  sh_q       <= nxt_q;
                  sdo_q      <= nxt_q[7];
                end
              end
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_STOP: begin
          if (div_q == DIV_LAST) begin
            cs_n_q  <= 1'b1;
            latch_q <= 1'b1;
            state_q <= S_LATCH;
            div_q   <= 16'd0;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_LATCH: begin
          if (latch_exit) begin
            latch_q     <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 8'd1;
            div_q       <= 16'd0;
            if (pending_q || frame_done) begin
              wr_bank_q <= ~wr_bank_q;
              pending_q <= 1'b0;
              state_q   <= S_START;
              cs_n_q    <= 1'b0;
              rd_addr_q <= 9'd0;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_sclk      = sclk_q;
  assign o_sdo       = sdo_q;
  assign o_cs_n      = cs_n_q;
  assign o_latch     = latch_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_overrun   = overrun_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_zone_bl_spi_tx.sv
// Directed bench for zone_bl_spi_tx: capture, gain, serial framing, overrun,
// incomplete-frame error and reset during transfer.
module tb_zone_bl_spi_tx;
  localparam int CD   = 2;
  localparam int LCYC = 8;

  logic       clk = 1'b0;
  logic       rst, flag_done, r_Vsync_0;
  logic [8:0] cnt_360;
  logic [7:0] buf_360_flatted, global_gain;
  logic       o_sclk, o_sdo, o_cs_n, o_latch, o_busy, o_overrun, o_err;
  logic [7:0] o_frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  zone_bl_spi_tx #(.ZONES(360), .CLK_DIV(CD), .HDR(8'hA5), .LATCH_CYC(LCYC)) dut (
    .i_pix_clk(clk), .rst(rst), .flag_done(flag_done), .cnt_360(cnt_360),
    .buf_360_flatted(buf_360_flatted), .r_Vsync_0(r_Vsync_0), .global_gain(global_gain),
    .o_sclk(o_sclk), .o_sdo(o_sdo), .o_cs_n(o_cs_n), .o_latch(o_latch), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt), .o_overrun(o_overrun), .o_err(o_err)
  );

  // Serial receiver: sampled on the falling clock edge, away from DUT updates
  logic [7:0] rx_q [$];
  int         rise_cnt = 0;
  int         bit_n    = 0;
  logic [7:0] acc      = 8'd0;
  logic       sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (o_sclk === 1'b1 && sclk_prev === 1'b0) begin
      rise_cnt++;
      if (o_cs_n === 1'b0) begin
        acc = {acc[6:0], o_sdo};
        bit_n++;
        if (bit_n == 8) begin
          rx_q.push_back(acc);
          bit_n = 0;
        end
      end
    end
    if (o_cs_n !== 1'b0) bit_n = 0;
    sclk_prev = o_sclk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: data = zone index, mode 1: data = 200
  task automatic write_frame(input int mode);
    for (int i = 0; i < 360; i++) begin
      flag_done       = 1'b1;
      cnt_360         = 9'((i + 1) % 360);
      buf_360_flatted = (mode == 1) ? 8'd200 : 8'(i);
      tick;
    end
    flag_done = 1'b0;
  endtask

  // mode 0: identity of index, 1: all 100, 2: index halved
  task automatic check_bytes(input string tag, input int b0, input int mode);
    int nb;
    logic [7:0] e;
    nb = 0;
    chk({tag, "_hdr"}, (rx_q.size() > b0) ? 32'(rx_q[b0]) : 32'hFFFF, 32'hA5);
    if (rx_q.size() >= b0 + 361) begin
      for (int i = 0; i < 360; i++) begin
        e = (mode == 1) ? 8'd100 : (mode == 2) ? 8'((i % 256) / 2) : 8'(i);
        if (rx_q[b0 + 1 + i] !== e) nb++;
      end
    end else begin
      nb = 360;
    end
    chk({tag, "_data_bad"}, nb, 0);
  endtask

  initial begin
    int r0, b0, k, gap, lat, cl, b3;
    rst = 1'b1; flag_done = 1'b0; cnt_360 = 9'd0; buf_360_flatted = 8'd0;
    r_Vsync_0 = 1'b0; global_gain = 8'd255;
    repeat (3) tick;
    chk("rst_sclk", o_sclk, 0);
    chk("rst_sdo", o_sdo, 0);
    chk("rst_cs_n", o_cs_n, 1);
    chk("rst_latch", o_latch, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (1000) tick;
    chk("idle_rises", rise_cnt - r0, 0);
    chk("idle_cs_n", o_cs_n, 1);

    // Frame 1: index data, unity gain; frame 2 written during its transmit
    r0 = rise_cnt; b0 = rx_q.size();
    write_frame(0);
    chk("f1_cs_low", o_cs_n, 0);
    chk("f1_busy", o_busy, 1);
    write_frame(1);
    chk("f2_overrun", o_overrun, 1);
    chk("f2_err_clear", o_err, 0);
    chk("f1_frame_cnt0", o_frame_cnt, 0);
    k = 0;
    while (o_cs_n === 1'b0 && k < 20000) begin tick; k++; end
    chk("f1_end_in_time", o_cs_n, 1);
    chk("f1_rises", rise_cnt - r0, 2888);
    check_bytes("f1", b0, 0);
    global_gain = 8'd127;
    gap = 0; lat = 0;
    while (o_cs_n === 1'b1 && gap < 100) begin
      if (o_latch === 1'b1) lat++;
      gap++;
      tick;
    end
    chk("f1_latch_cycles", lat, LCYC);
    chk("gap_in_range", (gap >= LCYC && gap <= CD + LCYC), 1);
    chk("f1_frame_cnt1", o_frame_cnt, 1);
    chk("f2_busy", o_busy, 1);

    r0 = rise_cnt; b0 = rx_q.size(); cl = 0;
    while (o_cs_n === 1'b0 && cl < 20000) begin cl++; tick; end
    chk("f2_cs_low_cycles", cl, 2 * CD + 361 * 16 * CD);
    k = 0;
    while (o_busy === 1'b1 && k < 100) begin tick; k++; end
    chk("f2_idle", o_busy, 0);
    chk("f2_rises", rise_cnt - r0, 2888);
    chk("f2_frame_cnt2", o_frame_cnt, 2);
    check_bytes("f2", b0, 1);

    // Incomplete frame: 100 writes, vsync restart, then the last zone
    for (int i = 1; i <= 100; i++) begin
      flag_done = 1'b1; cnt_360 = 9'(i); buf_360_flatted = 8'(i); tick;
    end
    flag_done = 1'b0; r_Vsync_0 = 1'b1; tick;
    r_Vsync_0 = 1'b0; tick;
    chk("inc_err_before", o_err, 0);
    flag_done = 1'b1; cnt_360 = 9'd0; tick;
    flag_done = 1'b0;
    repeat (20) tick;
    chk("inc_err", o_err, 1);
    chk("inc_no_tx", o_busy, 0);
    chk("inc_cs_n", o_cs_n, 1);
    chk("inc_frame_cnt", o_frame_cnt, 2);

    // Reset during data byte 150
    global_gain = 8'd255;
    b3 = rx_q.size();
    write_frame(0);
    k = 0;
    while (rx_q.size() - b3 < 151 && k < 20000) begin tick; k++; end
    chk("f3_reach_byte150", (rx_q.size() - b3 >= 151), 1);
    rst = 1'b1; tick;
    chk("mid_rst_cs_n", o_cs_n, 1);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_sclk", o_sclk, 0);
    chk("mid_rst_sdo", o_sdo, 0);
    chk("mid_rst_frame_cnt", o_frame_cnt, 0);
    chk("mid_rst_err", o_err, 0);
    chk("mid_rst_overrun", o_overrun, 0);
    rst = 1'b0; tick;

    // Frame 4 after reset: index data at half gain
    global_gain = 8'd127;
    r0 = rise_cnt; b0 = rx_q.size();
    write_frame(0);
    chk("f4_cs_low", o_cs_n, 0);
    k = 0;
    while (o_busy === 1'b1 && k < 20000) begin tick; k++; end
    chk("f4_idle", o_busy, 0);
    chk("f4_rises", rise_cnt - r0, 2888);
    chk("f4_frame_cnt", o_frame_cnt, 1);
    chk("f4_overrun", o_overrun, 0);
    check_bytes("f4", b0, 2);

    // Out-of-range counter: address 399 is not a zone
    chk("oor_err_before", o_err, 0);
    flag_done = 1'b1; cnt_360 = 9'd400; tick;
    flag_done = 1'b0; tick;
    chk("oor_err", o_err, 1);
    chk("oor_no_tx", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
